// File: rtl/hopfield_convergence_monitor.sv
// hopfield_convergence_monitor
// Watches the spike vector of a Hopfield network during a recall run and
// reports how the run ended: it converged (vector unchanged for STABLE_CYCLES
// consecutive comparisons), it hit TIMEOUT_CYCLES, or, optionally, it locked
// into a period-2 oscillation.
// Optional feature macro: HOPFIELD_OSC_DETECT_EN enables period-2 oscillation
// detection. Without it, oscillating is tied low and oscillating runs end by
// timeout.
module hopfield_convergence_monitor #(
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] spikes_in,
  output logic       busy,
  output logic       done,
  output logic       converged,
  output logic       timed_out,
  output logic       oscillating,
  output logic [6:0] pattern_out,
  output logic [7:0] settle_cycles,
  output logic [2:0] active_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] STABLE_LIM  = 4'(STABLE_CYCLES);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t     state_reg, state_next;
  logic [6:0] prev_reg;
  logic [7:0] cycle_cnt_reg, cycle_cnt_next;
  logic [3:0] stable_cnt_reg, stable_cnt_next;
  logic       converged_reg, timed_out_reg;
  logic [6:0] pattern_reg;
  logic [7:0] settle_reg;
  logic [2:0] active_reg;
  logic [2:0] active_next;
  logic       hit_conv, hit_timeout, hit_osc, terminate;

`ifdef HOPFIELD_OSC_DETECT_EN
  logic [6:0] prev2_reg;
  logic [3:0] osc_cnt_reg, osc_cnt_next;
  logic       oscillating_reg;
`endif

  // Per-cycle counter updates and termination conditions for a SETTLE cycle.
  always_comb begin
    cycle_cnt_next  = (cycle_cnt_reg == 8'hFF) ? cycle_cnt_reg : cycle_cnt_reg + 8'd1;
    stable_cnt_next = (spikes_in == prev_reg) ? stable_cnt_reg + 4'd1 : 4'd0;
    hit_conv        = (stable_cnt_next == STABLE_LIM);
    hit_timeout     = (cycle_cnt_next == TIMEOUT_LIM);
    hit_osc         = 1'b0;
`ifdef HOPFIELD_OSC_DETECT_EN
    osc_cnt_next = ((spikes_in == prev2_reg) && (spikes_in != prev_reg)) ?
                   osc_cnt_reg + 4'd1 : 4'd0;
    hit_osc      = (osc_cnt_next == STABLE_LIM);
`endif
    terminate = hit_conv | hit_osc | hit_timeout;
  end

  // Population count of the live spike vector, latched at termination.
  always_comb begin
    active_next = 3'd0;
    for (int i = 0; i < 7; i++) begin
      active_next = active_next + 3'(spikes_in[i]);
    end
  end

  // Next-state logic: abort beats every termination condition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = SETTLE;
      end
      SETTLE: begin
        if (abort)          state_next = IDLE;
        else if (terminate) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // History, counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg        <= '0;
      cycle_cnt_reg   <= '0;
      stable_cnt_reg  <= '0;
      converged_reg   <= 1'b0;
      timed_out_reg   <= 1'b0;
      pattern_reg     <= '0;
      settle_reg      <= '0;
      active_reg      <= '0;
`ifdef HOPFIELD_OSC_DETECT_EN
      prev2_reg       <= '0;
      osc_cnt_reg     <= '0;
      oscillating_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            prev_reg       <= spikes_in;
            cycle_cnt_reg  <= '0;
            stable_cnt_reg <= '0;
            converged_reg  <= 1'b0;
            timed_out_reg  <= 1'b0;
`ifdef HOPFIELD_OSC_DETECT_EN
            // Seeding prev2 with the start sample keeps stale history from a
            // previous run out of the first oscillation comparison.
            prev2_reg       <= spikes_in;
            osc_cnt_reg     <= '0;
            oscillating_reg <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (!abort) begin
            cycle_cnt_reg  <= cycle_cnt_next;
            stable_cnt_reg <= stable_cnt_next;
            prev_reg       <= spikes_in;
`ifdef HOPFIELD_OSC_DETECT_EN
            prev2_reg   <= prev_reg;
            osc_cnt_reg <= osc_cnt_next;
`endif
            if (hit_conv) begin
              converged_reg <= 1'b1;
`ifdef HOPFIELD_OSC_DETECT_EN
            end else if (hit_osc) begin
              oscillating_reg <= 1'b1;
`endif
            end else if (hit_timeout) begin
              timed_out_reg <= 1'b1;
            end
            if (terminate) begin
              pattern_reg <= spikes_in;
              settle_reg  <= cycle_cnt_next;
              active_reg  <= active_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_reg == SETTLE);
  assign done          = (state_reg == DONE);
  assign converged     = converged_reg;
  assign timed_out     = timed_out_reg;
  assign pattern_out   = pattern_reg;
  assign settle_cycles = settle_reg;
  assign active_count  = active_reg;
`ifdef HOPFIELD_OSC_DETECT_EN
  assign oscillating   = oscillating_reg;
`else
  assign oscillating   = 1'b0;
`endif

endmodule

// File: tb/tb_hopfield_convergence_monitor.sv
// Testbench for hopfield_convergence_monitor (STABLE_CYCLES=4, TIMEOUT_CYCLES=20).
// Directed scenarios plus randomized spike streams checked against a
// run-length based reference model. Honours HOPFIELD_OSC_DETECT_EN.
module tb_hopfield_convergence_monitor;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] spikes_in = 7'h0;
  logic       busy, done, converged, timed_out, oscillating;
  logic [6:0] pattern_out;
  logic [7:0] settle_cycles;
  logic [2:0] active_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] stim [0:63];

  always #5 clk = ~clk;

  hopfield_convergence_monitor #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .spikes_in    (spikes_in),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .timed_out    (timed_out),
    .oscillating  (oscillating),
    .pattern_out  (pattern_out),
    .settle_cycles(settle_cycles),
    .active_count (active_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got running, need finished)");
    $fatal(1, "watchdog");
  end

  // Reference model: walk the settle cycles and measure run lengths backwards.
  // kind: 1 converged, 2 timed out, 3 oscillating. cyc: terminating settle cycle.
  function automatic void model_run(output int kind, output int cyc);
    int run_s, run_o, j;
    kind = 0;
    cyc  = -1;
    for (int k = 1; k <= TIMEOUT; k++) begin
      run_s = 0;
      j = k;
      while (j >= 1) begin
        if (stim[j] != stim[j-1]) break;
        run_s++;
        j--;
      end
      run_o = 0;
      j = k;
      while (j >= 2) begin
        if (!(stim[j] == stim[j-2] && stim[j] != stim[j-1])) break;
        run_o++;
        j--;
      end
      if (run_s == STABLE) begin
        kind = 1; cyc = k; return;
      end
`ifdef HOPFIELD_OSC_DETECT_EN
      if (run_o == STABLE) begin
        kind = 3; cyc = k; return;
      end
`endif
      if (k == TIMEOUT) begin
        kind = 2; cyc = k; return;
      end
    end
  endfunction

  // Starts a run with stim[0], then feeds stim[k] on settle cycle k.
  // done_k = settle cycle where done was seen, -1 if never, -2 if aborted.
  task automatic drive_run(input int max_k, input int start_at, input int abort_at,
                           output int done_k);
    done_k = -1;
    @(posedge clk); #1;
    start = 1'b1;
    spikes_in = stim[0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      spikes_in = stim[k];
      start = (k == start_at);
      abort = (k == abort_at);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (k == abort_at) begin
        done_k = -2;
        break;
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    spikes_in = 7'h7F;
    #12;
    tests_run++;
    if ({busy, done, converged, timed_out, oscillating} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b need 00000", {busy, done, converged, timed_out, oscillating});
    end
    tests_run++;
    if (pattern_out !== 7'h0 || settle_cycles !== 8'h0 || active_count !== 3'h0) begin
      tests_failed++;
      $display("FAIL reset_results: got pat=%h settle=%0d act=%0d need 0/0/0",
               pattern_out, settle_cycles, active_count);
    end
    #11 rst_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_converge();
    int dk;
    for (int k = 0; k < 64; k++) stim[k] = 7'h2A;
    @(posedge clk); #1;
    start = 1'b1; spikes_in = stim[0];
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL conv_busy: got %b need 1", busy);
    end
    dk = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) begin dk = k; break; end
    end
    tests_run++;
    if (dk !== 4 || converged !== 1'b1 || timed_out !== 1'b0 || oscillating !== 1'b0) begin
      tests_failed++;
      $display("FAIL conv_result: got cyc=%0d c=%b t=%b o=%b need cyc=4 c=1 t=0 o=0",
               dk, converged, timed_out, oscillating);
    end
    tests_run++;
    if (pattern_out !== 7'h2A || settle_cycles !== 8'd4 || active_count !== 3'd3 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL conv_latch: got pat=%h settle=%0d act=%0d busy=%b need 2a/4/3/0",
               pattern_out, settle_cycles, active_count, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || converged !== 1'b1 || pattern_out !== 7'h2A) begin
      tests_failed++;
      $display("FAIL conv_hold: got done=%b c=%b pat=%h need done=0 c=1 pat=2a",
               done, converged, pattern_out);
    end
    $display("[TB] converge run: done at %0d", dk);
  endtask

  task automatic test_abort();
    int dk;
    bit saw_done;
    for (int k = 0; k < 64; k++) stim[k] = 7'(k + 5);
    drive_run(10, -1, 3, dk);
    tests_run++;
    if (dk !== -2 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_exit: got dk=%0d busy=%b done=%b need -2/0/0", dk, busy, done);
    end
    tests_run++;
    if (converged !== 1'b0 || timed_out !== 1'b0 || oscillating !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_flags: got c=%b t=%b o=%b need 000", converged, timed_out, oscillating);
    end
    tests_run++;
    if (pattern_out !== 7'h2A || settle_cycles !== 8'd4 || active_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL abort_keep: got pat=%h settle=%0d act=%0d need 2a/4/3",
               pattern_out, settle_cycles, active_count);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done) begin
      tests_failed++; $display("FAIL abort_quiet: got activity after abort, need none");
    end
    $display("[TB] abort run: aborted at settle cycle 3");
  endtask

  task automatic test_start_ignored();
    int dk;
    for (int k = 0; k < 64; k++) stim[k] = 7'h13;
    drive_run(10, 2, -1, dk);
    tests_run++;
    if (dk !== 4 || settle_cycles !== 8'd4 || converged !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_in_settle: got cyc=%0d settle=%0d c=%b need 4/4/1",
               dk, settle_cycles, converged);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_in_done: got busy=%b done=%b need 0/0", busy, done);
    end
    $display("[TB] start-ignored run: done at %0d", dk);
  endtask

  task automatic test_timeout();
    int dk;
    for (int k = 0; k < 64; k++) stim[k] = 7'(k * 5 + 1);
    drive_run(25, -1, -1, dk);
    tests_run++;
    if (dk !== 20 || timed_out !== 1'b1 || converged !== 1'b0 || oscillating !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_result: got cyc=%0d t=%b c=%b o=%b need 20/1/0/0",
               dk, timed_out, converged, oscillating);
    end
    tests_run++;
    if (settle_cycles !== 8'd20 || pattern_out !== 7'h65 || active_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL timeout_latch: got settle=%0d pat=%h act=%0d need 20/65/4",
               settle_cycles, pattern_out, active_count);
    end
    $display("[TB] timeout run: done at %0d", dk);
  endtask

  task automatic test_oscillation();
    int dk;
    for (int k = 0; k < 64; k++) stim[k] = (k % 2 == 0) ? 7'h55 : 7'h2A;
    drive_run(25, -1, -1, dk);
`ifdef HOPFIELD_OSC_DETECT_EN
    tests_run++;
    if (dk !== 5 || oscillating !== 1'b1 || converged !== 1'b0 || timed_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL osc_result: got cyc=%0d o=%b c=%b t=%b need 5/1/0/0",
               dk, oscillating, converged, timed_out);
    end
    tests_run++;
    if (settle_cycles !== 8'd5 || pattern_out !== 7'h2A || active_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL osc_latch: got settle=%0d pat=%h act=%0d need 5/2a/3",
               settle_cycles, pattern_out, active_count);
    end
`else
    tests_run++;
    if (dk !== 20 || timed_out !== 1'b1 || oscillating !== 1'b0 || converged !== 1'b0) begin
      tests_failed++;
      $display("FAIL osc_result: got cyc=%0d t=%b o=%b c=%b need 20/1/0/0",
               dk, timed_out, oscillating, converged);
    end
    tests_run++;
    if (settle_cycles !== 8'd20 || pattern_out !== 7'h55 || active_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL osc_latch: got settle=%0d pat=%h act=%0d need 20/55/4",
               settle_cycles, pattern_out, active_count);
    end
`endif
    $display("[TB] alternating run: done at %0d", dk);
  endtask

  task automatic test_coincidence();
    int dk;
    for (int k = 0; k < 64; k++) stim[k] = (k <= 16) ? 7'(k + 1) : 7'd17;
    drive_run(25, -1, -1, dk);
    tests_run++;
    if (dk !== 20 || converged !== 1'b1 || timed_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL coincide_prio: got cyc=%0d c=%b t=%b need 20/1/0", dk, converged, timed_out);
    end
    tests_run++;
    if (settle_cycles !== 8'd20 || pattern_out !== 7'h11 || active_count !== 3'd2) begin
      tests_failed++;
      $display("FAIL coincide_latch: got settle=%0d pat=%h act=%0d need 20/11/2",
               settle_cycles, pattern_out, active_count);
    end
    $display("[TB] coincidence run: done at %0d", dk);
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    @(posedge clk); #1;
    start = 1'b1; spikes_in = 7'h7F;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, converged, timed_out, oscillating} !== 5'b0 ||
        pattern_out !== 7'h0 || settle_cycles !== 8'h0 || active_count !== 3'h0) begin
      tests_failed++;
      $display("FAIL midrun_reset: got flags=%b pat=%h settle=%0d act=%0d need all 0",
               {busy, done, converged, timed_out, oscillating}, pattern_out, settle_cycles, active_count);
    end
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done) begin
      tests_failed++; $display("FAIL midrun_discard: got done/busy after reset, need none");
    end
    $display("[TB] mid-run reset checked");
  endtask

  task automatic test_random();
    int dk, kind, cyc, p_rep, r;
    for (int run = 0; run < 40; run++) begin
      p_rep = $urandom_range(3, 8);
      stim[0] = 7'($urandom);
      for (int k = 1; k < 64; k++) begin
        r = $urandom_range(0, 9);
        if (r < p_rep)                 stim[k] = stim[k-1];
        else if (r < 9 && k >= 2)      stim[k] = stim[k-2];
        else                           stim[k] = 7'($urandom);
      end
      model_run(kind, cyc);
      drive_run(TIMEOUT + 5, -1, -1, dk);
      tests_run++;
      if (dk !== cyc || converged !== (kind == 1) || timed_out !== (kind == 2) ||
          oscillating !== (kind == 3)) begin
        tests_failed++;
        $display("FAIL rand_end run %0d: got cyc=%0d c=%b t=%b o=%b need cyc=%0d kind=%0d",
                 run, dk, converged, timed_out, oscillating, cyc, kind);
      end
      tests_run++;
      if (pattern_out !== stim[cyc] || settle_cycles !== 8'(cyc) ||
          active_count !== 3'($countones(stim[cyc]))) begin
        tests_failed++;
        $display("FAIL rand_latch run %0d: got pat=%h settle=%0d act=%0d need %h/%0d/%0d",
                 run, pattern_out, settle_cycles, active_count, stim[cyc], cyc,
                 $countones(stim[cyc]));
      end
      $display("[TB] random run %0d: kind=%0d cycle=%0d", run, kind, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_converge();
    test_abort();
    test_start_ignored();
    test_timeout();
    test_oscillation();
    test_coincidence();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hopfield_convergence_monitor.md
HOPFIELD_CONVERGENCE_MONITOR -- requirements
Module: hopfield_convergence_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 8, meaning consecutive unchanged-spike comparisons needed to declare convergence (legal range 2..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200, meaning maximum settle cycles before abandoning a run (legal range STABLE_CYCLES+1..255).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin monitoring a recall run.
REQ-006 SHALL have port abort  input  1  cancels an in-progress run.
REQ-007 SHALL have port spikes_in  input  7  per-neuron spike vector from the Hopfield network, sampled every cycle.
REQ-008 SHALL have port busy  output  1  high while a run is being monitored.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a run terminates by convergence, timeout or oscillation.
REQ-010 SHALL have port converged  output  1  sticky result: last run converged.
REQ-011 SHALL have port timed_out  output  1  sticky result: last run hit TIMEOUT_CYCLES.
REQ-012 SHALL have port oscillating  output  1  sticky result: last run ended in a period-2 cycle.
REQ-013 SHALL have port pattern_out  output  7  spike vector held at termination.
REQ-014 SHALL have port settle_cycles  output  8  settle cycles elapsed at termination.
REQ-015 SHALL have port active_count  output  3  popcount of pattern_out.

Function
REQ-016 SHALL implement states IDLE, SETTLE, DONE; busy = (state == SETTLE).
REQ-017 SHALL, in IDLE with start high, load prev = spikes_in, clear cycle_cnt, stable_cnt, osc_cnt and all sticky results, and enter SETTLE next cycle.
REQ-018 SHALL, each SETTLE cycle, increment cycle_cnt (saturating at 255); if spikes_in == prev, increment stable_cnt, else clear stable_cnt; then load prev2 = prev and prev = spikes_in.
REQ-019 SHALL, on a SETTLE cycle where updated stable_cnt == STABLE_CYCLES, set converged, latch pattern_out = spikes_in, and enter DONE.
REQ-020 SHALL, on a SETTLE cycle where updated cycle_cnt == TIMEOUT_CYCLES without convergence, set timed_out, latch pattern_out = spikes_in, and enter DONE.
REQ-021 SHALL give convergence priority over timeout and oscillation when conditions coincide in one cycle.
REQ-022 SHALL latch settle_cycles = updated cycle_cnt and active_count = popcount(spikes_in) in the same terminating cycle.
REQ-023 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE; results hold until the next accepted start.
REQ-024 SHALL ignore start while in SETTLE or DONE.
REQ-025 SHALL, on abort in SETTLE, return to IDLE next cycle with no done pulse, all sticky results low, and pattern_out, settle_cycles and active_count unchanged; abort SHALL have priority over all termination conditions.
REQ-026 SHALL ignore abort outside SETTLE; start and abort high together in IDLE SHALL start a run.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE; busy, done, converged, timed_out, oscillating = 0; pattern_out = 0; settle_cycles = 0; active_count = 0; all internal counters and history registers = 0.
REQ-028 SHALL, on reset asserted mid-run, discard the run with no done pulse.

Configuration
REQ-029 SHALL compile oscillation detection only when macro HOPFIELD_OSC_DETECT_EN is defined.
REQ-030 SHALL, with the macro defined, increment osc_cnt on each SETTLE cycle where spikes_in == prev2 and spikes_in != prev (else clear it); at osc_cnt == STABLE_CYCLES, set oscillating, latch the results of REQ-022, and enter DONE.
REQ-031 SHALL, without the macro, tie oscillating to 0 and omit prev2 and osc_cnt; such runs SHALL end by timeout.

Verification
REQ-032 SHALL cover: STABLE_CYCLES=4, TIMEOUT=20; start, spikes constant 7'h2A -> done at settle_cycles=4, converged=1, pattern_out=7'h2A, active_count=3.
REQ-033 SHALL cover: spikes change every cycle for 25 cycles -> done at settle_cycles=20, timed_out=1, converged=0.
REQ-034 SHALL cover: spikes alternate 7'h55/7'h2A with macro defined -> oscillating=1 at settle_cycles=5; without macro -> timed_out=1 at 20.
REQ-035 SHALL cover: abort at settle cycle 3 -> no done pulse, busy low next cycle, prior results unchanged; start during SETTLE -> ignored.
REQ-036 SHALL cover: rst_n low mid-run -> all outputs 0 asynchronously; first stable-to-timeout coincidence (stable_cnt reaches 4 on cycle 20) -> converged=1, timed_out=0.
